// File: rtl/goto_chk_pkg.sv
// Shared types, default sizes and helpers for the goto-repetition checker.
package goto_chk_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } chk_state_e;

    // Counter width able to hold the value n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int GET_REPS_DEF = 2;
    localparam int PUT_REPS_DEF = 2;
    localparam int TIMEOUT_DEF  = 16;
    localparam int GET_W_DEF    = $clog2(GET_REPS_DEF + 1);
    localparam int PUT_W_DEF    = $clog2(PUT_REPS_DEF + 1);
    localparam int TMR_W_DEF    = $clog2(TIMEOUT_DEF + 1);

    // Add b to a, clamping at lim (covers wrap of the 64-bit sum too).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] lim);
        logic [63:0] s;
        s = a + b;
        return ((s > lim) || (s < a)) ? lim : s;
    endfunction

endpackage

// File: rtl/goto_chk_chan.sv
// One checker channel: antecedent detector, IDLE/CHECK FSM, put counter.
// GOTO_CHK_TIMEOUT_EN adds a per-attempt timer that fails stale attempts.
module goto_chk_chan
    import goto_chk_pkg::*;
#(
    parameter int G  = GET_REPS_DEF,
    parameter int P  = PUT_REPS_DEF,
    parameter int TO = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic get,
    input  logic put,
    input  logic stop,
    output logic busy_d,
    output logic pass_d,
    output logic fail_d,
    output logic drop_d
);
    localparam int RW = cnt_w(G);
    localparam int PW = cnt_w(P);

    logic [G-1:0]  go_pipe;
    logic [RW-1:0] get_run;
    logic          match;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            go_pipe <= '0;
            get_run <= '0;
        end else begin
            go_pipe[0] <= go;
            for (int k = 1; k < G; k++) go_pipe[k] <= go_pipe[k-1];
            get_run <= !get ? '0 : (get_run == RW'(G)) ? get_run : get_run + 1'b1;
        end
    end

    // get_run covers ticks before this one; the current get closes the run.
    assign match = go_pipe[G-1] & get & (get_run >= RW'(G - 1));

    chk_state_e    state, state_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic          in_chk, active, done, to_hit;

    assign in_chk = (state == CHECK);
    assign active = in_chk | (match & (state == IDLE));
    assign done   = put & ((in_chk ? pcnt : '0) == PW'(P - 1));

`ifdef GOTO_CHK_TIMEOUT_EN
    localparam int TW = cnt_w(TO);
    logic [TW-1:0] tmr, tmr_n;

    assign to_hit = in_chk & (tmr == TW'(TO - 1));
`else
    logic unused_to;

    assign unused_to = (TO > 0);
    assign to_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pcnt  <= '0;
`ifdef GOTO_CHK_TIMEOUT_EN
            tmr   <= '0;
`endif
        end else begin
            state <= state_n;
            pcnt  <= pcnt_n;
`ifdef GOTO_CHK_TIMEOUT_EN
            tmr   <= tmr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
`ifdef GOTO_CHK_TIMEOUT_EN
        tmr_n   = tmr;
`endif
        case (state)
            IDLE: begin
                if (match && !stop && !done) begin
                    state_n = CHECK;
                    pcnt_n  = PW'(put);
`ifdef GOTO_CHK_TIMEOUT_EN
                    tmr_n   = '0;
`endif
                end
            end
            CHECK: begin
                if (stop || done || to_hit) begin
                    state_n = IDLE;
                end else begin
                    pcnt_n = pcnt + PW'(put);
`ifdef GOTO_CHK_TIMEOUT_EN
                    tmr_n  = tmr + 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Stop beats put-completion, which beats timeout.
    always_comb begin
        pass_d = active & ~stop & done;
        fail_d = active & (stop | (~done & to_hit));
        drop_d = in_chk & match;
        busy_d = in_chk | (state_n == CHECK);
    end

endmodule

// File: rtl/goto_rep_checker.sv
// Multi-channel checker for go ##1 get[*G] |-> sync_reject_on(stop) put[->P].
// Optional GOTO_CHK_TIMEOUT_EN enables per-channel attempt timeouts.
module goto_rep_checker
    import goto_chk_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int GET_REPS = GET_REPS_DEF,
    parameter int PUT_REPS = PUT_REPS_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] go,
    input  logic [CHANNELS-1:0] get,
    input  logic [CHANNELS-1:0] put,
    input  logic [CHANNELS-1:0] stop,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] pass,
    output logic [CHANNELS-1:0] fail,
    output logic [CHANNELS-1:0] drop,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    fail_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic [CHANNELS-1:0] busy_d, pass_d, fail_d, drop_d;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        goto_chk_chan #(
            .G  (GET_REPS),
            .P  (PUT_REPS),
            .TO (TIMEOUT)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .go     (go[ch]),
            .get    (get[ch]),
            .put    (put[ch]),
            .stop   (stop[ch]),
            .busy_d (busy_d[ch]),
            .pass_d (pass_d[ch]),
            .fail_d (fail_d[ch]),
            .drop_d (drop_d[ch])
        );
    end

    // Counters integrate the registered pulses, so they trail them by a cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            pass     <= '0;
            fail     <= '0;
            drop     <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            busy     <= busy_d;
            pass     <= pass_d;
            fail     <= fail_d;
            drop     <= drop_d;
            pass_cnt <= CNT_W'(sat_add(64'(pass_cnt), 64'($countones(pass)), CNT_MAX));
            fail_cnt <= CNT_W'(sat_add(64'(fail_cnt), 64'($countones(fail)), CNT_MAX));
            drop_cnt <= CNT_W'(sat_add(64'(drop_cnt), 64'($countones(drop)), CNT_MAX));
        end
    end

endmodule

// File: tb/tb_goto_rep_checker.sv
// Directed bench for goto_rep_checker: pass, stop, drop, timeout, reset and saturation.
module tb_goto_rep_checker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] go, get, put, stop;
    logic [3:0] busy, pass, fail, drop;
    logic [15:0] pass_cnt, fail_cnt, drop_cnt;
    logic [3:0] s_busy, s_pass, s_fail, s_drop;
    logic [1:0] s_pass_cnt, s_fail_cnt, s_drop_cnt;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    goto_rep_checker #(.CHANNELS(4), .GET_REPS(2), .PUT_REPS(2), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .get(get), .put(put), .stop(stop),
        .busy(busy), .pass(pass), .fail(fail), .drop(drop),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .drop_cnt(drop_cnt));

    goto_rep_checker #(.CHANNELS(4), .GET_REPS(2), .PUT_REPS(2), .TIMEOUT(16), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .go(go), .get(get), .put(put), .stop(stop),
        .busy(s_busy), .pass(s_pass), .fail(s_fail), .drop(s_drop),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .drop_cnt(s_drop_cnt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [3:0] eb, input logic [3:0] ep,
                        input logic [3:0] ef, input logic [3:0] ed);
        chk({tag, " busy"}, 64'(busy), 64'(eb));
        chk({tag, " pass"}, 64'(pass), 64'(ep));
        chk({tag, " fail"}, 64'(fail), 64'(ef));
        chk({tag, " drop"}, 64'(drop), 64'(ed));
    endtask

    // Drive one tick's inputs, clock them in, settle past the edge.
    task automatic drv(input logic [3:0] g, input logic [3:0] gt, input logic [3:0] p,
                       input logic [3:0] s);
        go = g; get = gt; put = p; stop = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic eb, ef;
        rst_n = 1'b0;
        go = '0; get = '0; put = '0; stop = '0;
        repeat (2) @(posedge clk);
        #1;
        chkv("rst", 4'b0, 4'b0, 4'b0, 4'b0);
        chk("rst pass_cnt", 64'(pass_cnt), 0);
        chk("rst fail_cnt", 64'(fail_cnt), 0);
        chk("rst drop_cnt", 64'(drop_cnt), 0);
        rst_n = 1'b1;
        drv(4'b0, 4'b0, 4'b0, 4'b0);

        // A: ch0 pass, ch1 stop in CHECK, ch2 stop+put in match cycle, ch3 short get run
        chkv("A1", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        chkv("A2", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b0000, 4'b1111, 4'b0000, 4'b0000);
        chkv("A3", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b0000, 4'b0111, 4'b0100, 4'b0100);
        chkv("A4", 4'b0011, 4'b0, 4'b0100, 4'b0); drv(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chkv("A5", 4'b0011, 4'b0, 4'b0, 4'b0);
        chk("A5 fail_cnt", 64'(fail_cnt), 1);     drv(4'b0000, 4'b0000, 4'b0011, 4'b0000);
        chkv("A6", 4'b0011, 4'b0, 4'b0, 4'b0);    drv(4'b0000, 4'b0000, 4'b0000, 4'b0010);
        chkv("A7", 4'b0011, 4'b0, 4'b0010, 4'b0); drv(4'b0000, 4'b0000, 4'b0001, 4'b0000);
        chkv("A8", 4'b0001, 4'b0001, 4'b0, 4'b0);
        chk("A8 fail_cnt", 64'(fail_cnt), 2);
        chk("A8 pass_cnt", 64'(pass_cnt), 0);     drv(4'b0, 4'b0, 4'b0, 4'b0);
        chkv("A9", 4'b0, 4'b0, 4'b0, 4'b0);
        chk("A9 pass_cnt", 64'(pass_cnt), 1);     drv(4'b0, 4'b0, 4'b0, 4'b0);

        // B: all channels armed, ch3 re-matches while busy, all pass together
        chkv("B1", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        chkv("B2", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b0000, 4'b1111, 4'b0000, 4'b0000);
        chkv("B3", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b1000, 4'b1111, 4'b0000, 4'b0000);
        chkv("B4", 4'b1111, 4'b0, 4'b0, 4'b0);    drv(4'b0000, 4'b1000, 4'b0000, 4'b0000);
        chkv("B5", 4'b1111, 4'b0, 4'b0, 4'b0);    drv(4'b0000, 4'b1000, 4'b0000, 4'b0000);
        chkv("B6", 4'b1111, 4'b0, 4'b0, 4'b1000); drv(4'b0000, 4'b0000, 4'b1111, 4'b0000);
        chkv("B7", 4'b1111, 4'b0, 4'b0, 4'b0);
        chk("B7 drop_cnt", 64'(drop_cnt), 1);     drv(4'b0000, 4'b0000, 4'b1111, 4'b0000);
        chkv("B8", 4'b1111, 4'b1111, 4'b0, 4'b0);
        chk("B8 pass_cnt", 64'(pass_cnt), 1);     drv(4'b0, 4'b0, 4'b0, 4'b0);
        chkv("B9", 4'b0, 4'b0, 4'b0, 4'b0);
        chk("B9 pass_cnt", 64'(pass_cnt), 5);     drv(4'b0, 4'b0, 4'b0, 4'b0);

        // C: ch0 stop beats completing put; ch1 passes and drops a match in its exit tick
        chkv("C1", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b0011, 4'b0000, 4'b0000, 4'b0000);
        chkv("C2", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b0000, 4'b0011, 4'b0000, 4'b0000);
        chkv("C3", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b0010, 4'b0011, 4'b0000, 4'b0000);
        chkv("C4", 4'b0011, 4'b0, 4'b0, 4'b0);    drv(4'b0000, 4'b0010, 4'b0011, 4'b0000);
        chkv("C5", 4'b0011, 4'b0, 4'b0, 4'b0);    drv(4'b0000, 4'b0010, 4'b0011, 4'b0001);
        chkv("C6", 4'b0011, 4'b0010, 4'b0001, 4'b0010); drv(4'b0, 4'b0, 4'b0, 4'b0);
        chkv("C7", 4'b0, 4'b0, 4'b0, 4'b0);
        chk("C7 pass_cnt", 64'(pass_cnt), 6);
        chk("C7 fail_cnt", 64'(fail_cnt), 3);
        chk("C7 drop_cnt", 64'(drop_cnt), 2);     drv(4'b0, 4'b0, 4'b0, 4'b0);

        // D: single put after match; timed build fails at 20, untimed stays busy
        drv(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        drv(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        drv(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        chkv("D4", 4'b0001, 4'b0, 4'b0, 4'b0);    drv(4'b0000, 4'b0000, 4'b0001, 4'b0000);
        for (int c = 5; c <= 22; c++) begin
`ifdef GOTO_CHK_TIMEOUT_EN
            eb = (c <= 20);
            ef = (c == 20);
`else
            eb = 1'b1;
            ef = 1'b0;
`endif
            chk($sformatf("D%0d busy0", c), 64'(busy[0]), 64'(eb));
            chk($sformatf("D%0d fail0", c), 64'(fail[0]), 64'(ef));
            drv(4'b0, 4'b0, 4'b0, 4'b0);
        end

        // E: reset lands while ch1 is mid-CHECK; attempt vanishes without a fail
        drv(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        drv(4'b0000, 4'b0010, 4'b0000, 4'b0000);
        drv(4'b0000, 4'b0010, 4'b0000, 4'b0000);
        chk("E4 busy1", 64'(busy[1]), 1);         drv(4'b0, 4'b0, 4'b0, 4'b0);
        drv(4'b0, 4'b0, 4'b0, 4'b0);
        rst_n = 1'b0;
        drv(4'b0, 4'b0, 4'b0, 4'b0);
        rst_n = 1'b1;
        chkv("E7", 4'b0, 4'b0, 4'b0, 4'b0);
        chk("E7 pass_cnt", 64'(pass_cnt), 0);
        chk("E7 fail_cnt", 64'(fail_cnt), 0);
        chk("E7 drop_cnt", 64'(drop_cnt), 0);     drv(4'b0, 4'b0, 4'b0, 4'b0);
        chkv("E8", 4'b0, 4'b0, 4'b0, 4'b0);       drv(4'b0, 4'b0, 4'b0, 4'b0);

        // F: put counted in match cycle; five passes saturate the 2-bit counter at 3
        drv(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        drv(4'b0000, 4'b1111, 4'b0000, 4'b0000);
        drv(4'b0000, 4'b1111, 4'b1111, 4'b0000);
        chkv("F4", 4'b1111, 4'b0, 4'b0, 4'b0);    drv(4'b0000, 4'b0000, 4'b1111, 4'b0000);
        chkv("F5", 4'b1111, 4'b1111, 4'b0, 4'b0); drv(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        chk("F6 pass_cnt", 64'(pass_cnt), 4);
        chk("F6 sat pass_cnt", 64'(s_pass_cnt), 3); drv(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        drv(4'b0000, 4'b0001, 4'b0001, 4'b0000);
        drv(4'b0000, 4'b0000, 4'b0001, 4'b0000);
        chkv("F9", 4'b0001, 4'b0001, 4'b0, 4'b0); drv(4'b0, 4'b0, 4'b0, 4'b0);
        chk("F10 pass_cnt", 64'(pass_cnt), 5);
        chk("F10 sat pass_cnt", 64'(s_pass_cnt), 3);
        chk("F10 sat fail_cnt", 64'(s_fail_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
